// File: rtl/ace_wb_pkg.sv
// Shared definitions for the writeback collector.
// Holds the source/port counts, field widths, source index names,
// the buffered result entry layout and a wrap-around index helper.
package ace_wb_pkg;

   localparam int NUM_SRC   = 6;
   localparam int NUM_WP    = 4;
   localparam int DATA_W    = 64;
   localparam int PREG_W    = 7;
   localparam int ROB_W     = 7;
   localparam int SRC_IDX_W = $clog2(NUM_SRC);

   localparam int SRC_ALU0 = 0;
   localparam int SRC_ALU1 = 1;
   localparam int SRC_ALU2 = 2;
   localparam int SRC_ALU3 = 3;
   localparam int SRC_MOB1 = 4;
   localparam int SRC_MOB2 = 5;

   typedef struct packed {
      logic              wdest;
      logic [PREG_W-1:0] preg;
      logic [ROB_W-1:0]  rob;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   // Next source index in round-robin order, wrapping at NUM_SRC.
   function automatic logic [SRC_IDX_W-1:0] nextSrc(input logic [SRC_IDX_W-1:0] idx);
      return (idx == SRC_IDX_W'(NUM_SRC - 1)) ? '0 : idx + 1'b1;
   endfunction

endpackage

// File: rtl/ace_wb_src_fifo.sv
// Per-source result buffer: a small power-of-two FIFO of wb_entry_t.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   i_flush       empties the FIFO (pointers and count to zero)
//   i_push        write i_pushEntry at the tail (caller guarantees not full)
//   i_pop         drop the head entry (caller guarantees not empty)
//   o_head        entry at the head
//   o_count       number of stored entries
//   o_full        count equals FIFO_DEPTH
//   o_empty       count is zero
module ace_wb_src_fifo
   import ace_wb_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_flush,
   input  logic             i_push,
   input  wb_entry_t        i_pushEntry,
   input  logic             i_pop,
   output wb_entry_t        o_head,
   output logic [CNT_W-1:0] o_count,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   wb_entry_t        r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;

   // Storage and pointers. Depth is a power of two so the pointers wrap
   // naturally; a simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wrPtr] <= i_pushEntry;
            r_wrPtr        <= r_wrPtr + 1'b1;
         end
         if (i_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rdPtr];
   assign o_count = r_count;
   assign o_full  = (r_count == CNT_W'(FIFO_DEPTH));
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/ace_wb_arbiter.sv
// Writeback collector: buffers results from 4 ALU pipes and 2 MOB ports in
// per-source FIFOs and round-robin arbitrates up to NUM_WP heads per cycle
// onto the register-file write ports, wakeup broadcast and ROB completion.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   flush          discard all buffered results, ignore same-cycle inputs
//   src_*          per-source result (valid/ready handshake, wdest, preg, data, rob)
//   wp_*           register file write (valid = wdest of granted entry)
//   wake_*         ready-bit wakeup (mirrors wp)
//   cmp_*          ROB completion (valid for every granted entry)
module ace_wb_arbiter
   import ace_wb_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic [NUM_SRC-1:0]        src_valid,
   output logic [NUM_SRC-1:0]        src_ready,
   input  logic [NUM_SRC-1:0]        src_wdest,
   input  logic [NUM_SRC*PREG_W-1:0] src_preg,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   input  logic [NUM_SRC*ROB_W-1:0]  src_rob,
   output logic [NUM_WP-1:0]         wp_valid,
   output logic [NUM_WP*PREG_W-1:0]  wp_preg,
   output logic [NUM_WP*DATA_W-1:0]  wp_data,
   output logic [NUM_WP-1:0]         wake_valid,
   output logic [NUM_WP*PREG_W-1:0]  wake_preg,
   output logic [NUM_WP-1:0]         cmp_valid,
   output logic [NUM_WP*ROB_W-1:0]   cmp_rob
);

   localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
   localparam int WP_IDX_W = $clog2(NUM_WP);
   localparam int NG_W     = $clog2(NUM_WP + 1);

   wb_entry_t            w_pushEntry [NUM_SRC];
   wb_entry_t            w_head      [NUM_SRC];
   logic [CNT_W-1:0]     w_count     [NUM_SRC];
   logic [NUM_SRC-1:0]   w_full;
   logic [NUM_SRC-1:0]   w_empty;
   logic [NUM_SRC-1:0]   w_push;
   logic [NUM_SRC-1:0]   w_grant;
   logic [NUM_WP-1:0]    w_slotValid;
   logic [SRC_IDX_W-1:0] w_slotSrc [NUM_WP];
   logic [SRC_IDX_W-1:0] w_lastSrc;

   logic [SRC_IDX_W-1:0]     r_rrPtr;
   logic [NUM_WP-1:0]        r_wpValid;
   logic [NUM_WP-1:0]        r_wakeValid;
   logic [NUM_WP-1:0]        r_cmpValid;
   logic [NUM_WP*PREG_W-1:0] r_wpPreg;
   logic [NUM_WP*DATA_W-1:0] r_wpData;
   logic [NUM_WP*ROB_W-1:0]  r_cmpRob;

   // One FIFO per source. Ready is derived from the registered count only,
   // so a pop in the same cycle never opens the door for an extra push.
   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      assign w_pushEntry[g].wdest = src_wdest[g];
      assign w_pushEntry[g].preg  = src_preg[g*PREG_W +: PREG_W];
      assign w_pushEntry[g].rob   = src_rob[g*ROB_W +: ROB_W];
      assign w_pushEntry[g].data  = src_data[g*DATA_W +: DATA_W];
      assign src_ready[g]         = (w_count[g] < CNT_W'(FIFO_DEPTH));
      assign w_push[g]            = src_valid[g] & ~w_full[g] & ~flush;

      ace_wb_src_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
         .clk         (clk),
         .reset       (reset),
         .i_flush     (flush),
         .i_push      (w_push[g]),
         .i_pushEntry (w_pushEntry[g]),
         .i_pop       (w_grant[g]),
         .o_head      (w_head[g]),
         .o_count     (w_count[g]),
         .o_full      (w_full[g]),
         .o_empty     (w_empty[g])
      );
   end

   // Round-robin scan starting at r_rrPtr: the k-th non-empty head found
   // is steered to write port k, until all write ports are taken.
   always_comb begin
      logic [SRC_IDX_W-1:0] idx;
      logic [NG_W-1:0]      nGrant;
      w_grant     = '0;
      w_slotValid = '0;
      w_lastSrc   = r_rrPtr;
      for (int p = 0; p < NUM_WP; p++) begin
         w_slotSrc[p] = '0;
      end
      idx    = r_rrPtr;
      nGrant = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (!w_empty[idx] && (nGrant < NG_W'(NUM_WP))) begin
            w_grant[idx]                        = 1'b1;
            w_slotValid[nGrant[WP_IDX_W-1:0]]   = 1'b1;
            w_slotSrc[nGrant[WP_IDX_W-1:0]]     = idx;
            w_lastSrc                           = idx;
            nGrant                              = nGrant + 1'b1;
         end
         idx = nextSrc(idx);
      end
   end

   // Registered output bundle and round-robin pointer. Flush clears the
   // bundle just like reset so nothing granted in the flush cycle escapes.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_rrPtr     <= '0;
         r_wpValid   <= '0;
         r_wakeValid <= '0;
         r_cmpValid  <= '0;
         r_wpPreg    <= '0;
         r_wpData    <= '0;
         r_cmpRob    <= '0;
      end else begin
         for (int p = 0; p < NUM_WP; p++) begin
            if (w_slotValid[p]) begin
               r_wpValid[p]                   <= w_head[w_slotSrc[p]].wdest;
               r_wakeValid[p]                 <= w_head[w_slotSrc[p]].wdest;
               r_cmpValid[p]                  <= 1'b1;
               r_wpPreg[p*PREG_W +: PREG_W]   <= w_head[w_slotSrc[p]].preg;
               r_wpData[p*DATA_W +: DATA_W]   <= w_head[w_slotSrc[p]].data;
               r_cmpRob[p*ROB_W +: ROB_W]     <= w_head[w_slotSrc[p]].rob;
            end else begin
               r_wpValid[p]                   <= 1'b0;
               r_wakeValid[p]                 <= 1'b0;
               r_cmpValid[p]                  <= 1'b0;
               r_wpPreg[p*PREG_W +: PREG_W]   <= '0;
               r_wpData[p*DATA_W +: DATA_W]   <= '0;
               r_cmpRob[p*ROB_W +: ROB_W]     <= '0;
            end
         end
         if (|w_grant) begin
            r_rrPtr <= nextSrc(w_lastSrc);
         end
      end
   end

   assign wp_valid   = r_wpValid;
   assign wp_preg    = r_wpPreg;
   assign wp_data    = r_wpData;
   assign wake_valid = r_wakeValid;
   assign wake_preg  = r_wpPreg;
   assign cmp_valid  = r_cmpValid;
   assign cmp_rob    = r_cmpRob;

endmodule

// File: tb/tb_ace_wb_arbiter.sv
// Testbench for ace_wb_arbiter: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_ace_wb_arbiter;
   import ace_wb_pkg::*;

   localparam int DEPTH = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                      reset;
   logic                      flush;
   logic [NUM_SRC-1:0]        src_valid;
   logic [NUM_SRC-1:0]        src_ready;
   logic [NUM_SRC-1:0]        src_wdest;
   logic [NUM_SRC*PREG_W-1:0] src_preg;
   logic [NUM_SRC*DATA_W-1:0] src_data;
   logic [NUM_SRC*ROB_W-1:0]  src_rob;
   logic [NUM_WP-1:0]         wp_valid;
   logic [NUM_WP*PREG_W-1:0]  wp_preg;
   logic [NUM_WP*DATA_W-1:0]  wp_data;
   logic [NUM_WP-1:0]         wake_valid;
   logic [NUM_WP*PREG_W-1:0]  wake_preg;
   logic [NUM_WP-1:0]         cmp_valid;
   logic [NUM_WP*ROB_W-1:0]   cmp_rob;

   wb_entry_t tbEntry [NUM_SRC];

   ace_wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .src_valid  (src_valid),
      .src_ready  (src_ready),
      .src_wdest  (src_wdest),
      .src_preg   (src_preg),
      .src_data   (src_data),
      .src_rob    (src_rob),
      .wp_valid   (wp_valid),
      .wp_preg    (wp_preg),
      .wp_data    (wp_data),
      .wake_valid (wake_valid),
      .wake_preg  (wake_preg),
      .cmp_valid  (cmp_valid),
      .cmp_rob    (cmp_rob)
   );

   // Flatten the per-source stimulus entries onto the DUT buses.
   always_comb begin
      src_wdest = '0;
      src_preg  = '0;
      src_data  = '0;
      src_rob   = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         src_wdest[i]                   = tbEntry[i].wdest;
         src_preg[i*PREG_W +: PREG_W]   = tbEntry[i].preg;
         src_data[i*DATA_W +: DATA_W]   = tbEntry[i].data;
         src_rob[i*ROB_W +: ROB_W]      = tbEntry[i].rob;
      end
   end

   // Reference model: one queue per source, a round-robin start index and
   // the expected output bundle for the cycle after each edge.
   wb_entry_t                mq [NUM_SRC][$];
   int                       mRr;
   logic [NUM_WP-1:0]        eWpValid, eWakeValid, eCmpValid;
   logic [NUM_WP*PREG_W-1:0] ePreg;
   logic [NUM_WP*DATA_W-1:0] eData;
   logic [NUM_WP*ROB_W-1:0]  eRob;
   int                       total = 0;
   int                       bad   = 0;
   int                       tagCnt = 0;

   task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock edge; returns which sources it accepted.
   task automatic modelEdge(output logic [NUM_SRC-1:0] acc);
      logic [NUM_SRC-1:0] canTake;
      int n, last, s;
      wb_entry_t e;
      acc        = '0;
      eWpValid   = '0;
      eWakeValid = '0;
      eCmpValid  = '0;
      ePreg      = '0;
      eData      = '0;
      eRob       = '0;
      if (reset || flush) begin
         for (int i = 0; i < NUM_SRC; i++) mq[i].delete();
         mRr = 0;
         return;
      end
      for (int i = 0; i < NUM_SRC; i++) canTake[i] = (mq[i].size() < DEPTH);
      n = 0;
      last = -1;
      for (int k = 0; k < NUM_SRC; k++) begin
         s = (mRr + k) % NUM_SRC;
         if (mq[s].size() != 0 && n < NUM_WP) begin
            e = mq[s].pop_front();
            eWpValid[n]                 = e.wdest;
            eWakeValid[n]               = e.wdest;
            eCmpValid[n]                = 1'b1;
            ePreg[n*PREG_W +: PREG_W]   = e.preg;
            eData[n*DATA_W +: DATA_W]   = e.data;
            eRob[n*ROB_W +: ROB_W]      = e.rob;
            n++;
            last = s;
         end
      end
      for (int i = 0; i < NUM_SRC; i++) begin
         if (src_valid[i] && canTake[i]) begin
            mq[i].push_back(tbEntry[i]);
            acc[i] = 1'b1;
         end
      end
      if (last >= 0) mRr = (last + 1) % NUM_SRC;
   endtask

   // One full cycle: check ready before the edge, step model and DUT,
   // check the registered outputs, retire accepted stimulus.
   task automatic stepCycle();
      logic [NUM_SRC-1:0] expReady, acc;
      for (int i = 0; i < NUM_SRC; i++) expReady[i] = (mq[i].size() < DEPTH);
      checkOutput("src_ready", src_ready, expReady);
      modelEdge(acc);
      @(posedge clk);
      @(negedge clk);
      checkOutput("wp_valid", wp_valid, eWpValid);
      checkOutput("wp_preg", wp_preg, ePreg);
      checkOutput("wp_data", wp_data, eData);
      checkOutput("wake_valid", wake_valid, eWakeValid);
      checkOutput("wake_preg", wake_preg, ePreg);
      checkOutput("cmp_valid", cmp_valid, eCmpValid);
      checkOutput("cmp_rob", cmp_rob, eRob);
      checkOutput("rr_ptr", dut.r_rrPtr, mRr);
      if (reset || flush) src_valid = '0;
      else                src_valid = src_valid & ~acc;
   endtask

   task automatic setEntry(input int i, input logic wd, input logic [PREG_W-1:0] pr,
                           input logic [ROB_W-1:0] rb, input logic [DATA_W-1:0] dt);
      tbEntry[i].wdest = wd;
      tbEntry[i].preg  = pr;
      tbEntry[i].rob   = rb;
      tbEntry[i].data  = dt;
      src_valid[i]     = 1'b1;
   endtask

   // Offer a new tagged result on idle sources with the given probability;
   // stalled sources keep holding their pending result.
   task automatic applyStimulus(input int prob);
      for (int i = 0; i < NUM_SRC; i++) begin
         if (!src_valid[i] && $urandom_range(99) < prob) begin
            setEntry(i, 1'($urandom_range(1)), 7'($urandom), 7'($urandom),
                     {32'(i), 32'(tagCnt)});
            tagCnt++;
         end
      end
   endtask

   initial begin
      logic stallSeen;
      reset     = 1'b1;
      flush     = 1'b0;
      src_valid = '0;
      for (int i = 0; i < NUM_SRC; i++) tbEntry[i] = '0;
      mRr = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Reset state
      stepCycle();
      checkOutput("reset cmp_valid", cmp_valid, 0);
      checkOutput("reset wp_data", wp_data, 0);
      reset = 1'b0;

      // Single result from source 2
      setEntry(SRC_ALU2, 1'b1, 7'h15, 7'd9, 64'hDEAD);
      stepCycle();
      stepCycle();
      checkOutput("single wp_valid", wp_valid, 4'b0001);
      checkOutput("single preg", wp_preg[6:0], 7'h15);
      checkOutput("single data", wp_data[63:0], 64'hDEAD);
      checkOutput("single wake_preg", wake_preg[6:0], 7'h15);
      checkOutput("single cmp_rob", cmp_rob, 28'd9);
      checkOutput("single rr", dut.r_rrPtr, 3);

      // Oversubscription: all six sources at once, rr starts at 0
      flush = 1'b1;
      stepCycle();
      flush = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) setEntry(i, 1'b1, 7'(i + 32), 7'(i), 64'(i));
      stepCycle();
      stepCycle();
      checkOutput("over first valid", wp_valid, 4'hF);
      checkOutput("over first rob", cmp_rob, {7'd3, 7'd2, 7'd1, 7'd0});
      checkOutput("over first rr", dut.r_rrPtr, 4);
      stepCycle();
      checkOutput("over second valid", wp_valid, 4'b0011);
      checkOutput("over second rob", cmp_rob, {14'd0, 7'd5, 7'd4});
      checkOutput("over second rr", dut.r_rrPtr, 0);

      // Back-pressure: every source saturating, source 0 must stall
      stallSeen = 1'b0;
      for (int c = 0; c < 14; c++) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (!src_valid[i]) begin
               setEntry(i, 1'b1, 7'(c), 7'(i), {32'(i), 32'(tagCnt)});
               tagCnt++;
            end
         end
         if (!src_ready[0]) stallSeen = 1'b1;
         stepCycle();
      end
      checkOutput("bp stall seen", stallSeen, 1'b1);
      src_valid = '0;
      repeat (6) stepCycle();

      // No-dest result from MOB1
      flush = 1'b1;
      stepCycle();
      flush = 1'b0;
      setEntry(SRC_MOB1, 1'b0, 7'h11, 7'h3A, 64'h55);
      stepCycle();
      stepCycle();
      checkOutput("nodest cmp_valid", cmp_valid, 4'b0001);
      checkOutput("nodest cmp_rob", cmp_rob[6:0], 7'h3A);
      checkOutput("nodest wp_valid", wp_valid, 4'b0000);
      checkOutput("nodest wake_valid", wake_valid, 4'b0000);

      // Flush mid-stream with a flush-cycle push on source 1
      for (int i = 0; i < 5; i++) setEntry(i, 1'b1, 7'(i), 7'(i), 64'hF00 + 64'(i));
      stepCycle();
      flush = 1'b1;
      setEntry(SRC_ALU1, 1'b1, 7'h7F, 7'h7F, 64'hBAD);
      stepCycle();
      flush = 1'b0;
      checkOutput("flush wp_valid", wp_valid, 4'b0000);
      checkOutput("flush cmp_valid", cmp_valid, 4'b0000);
      checkOutput("flush src_ready", src_ready, 6'b111111);
      repeat (3) stepCycle();

      // Reset during traffic
      repeat (5) begin
         applyStimulus(80);
         stepCycle();
      end
      reset = 1'b1;
      stepCycle();
      reset = 1'b0;
      checkOutput("rst cmp_valid", cmp_valid, 4'b0000);
      checkOutput("rst wp_data", wp_data, 0);
      checkOutput("rst rr", dut.r_rrPtr, 0);
      setEntry(SRC_ALU3, 1'b1, 7'h22, 7'h33, 64'h1234);
      stepCycle();
      stepCycle();
      checkOutput("rst push cmp_valid", cmp_valid, 4'b0001);
      checkOutput("rst push rob", cmp_rob[6:0], 7'h33);

      // Random traffic with occasional flush and reset
      for (int c = 0; c < 1500; c++) begin
         applyStimulus(60);
         flush = ($urandom_range(99) < 2);
         reset = ($urandom_range(199) == 0);
         stepCycle();
         flush = 1'b0;
         reset = 1'b0;
      end
      src_valid = '0;
      repeat (5) stepCycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
